// File: rtl/hamming_decoder.sv
// Bit-serial SECDED decoder for 16-bit Hamming codewords received as two bytes.
// It emits the 11 data bits and a 2-bit status as two bytes, and keeps saturating error counts.
module hamming_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic [7:0] corr_count,
  output logic [7:0] dbl_count
);

  typedef enum logic [2:0] {
    IDLE,
    GET_MSW,
    SCAN,
    FIX,
    OUT_LSW,
    OUT_MSW
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] w_reg;
  logic [3:0]  s_reg;
  logic        p_reg;
  logic [4:0]  cnt_reg;
  logic [7:0]  out_data_reg;
  logic [7:0]  out_msw_reg;
  logic        out_valid_reg;
  logic [7:0]  corr_count_reg;
  logic [7:0]  dbl_count_reg;

  logic        in_fire;
  logic        out_fire;
  logic [15:0] flip_mask;
  logic [15:0] w_fixed;
  logic [1:0]  status;

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign busy       = (state_reg != IDLE);
  assign corr_count = corr_count_reg;
  assign dbl_count  = dbl_count_reg;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  // Odd overall parity means a single error at position s; s=0 addresses p0 itself.
  assign flip_mask = p_reg ? (16'h0001 << s_reg) : 16'h0000;
  assign w_fixed   = w_reg ^ flip_mask;
  assign status    = p_reg ? 2'b01 : ((s_reg != 4'd0) ? 2'b10 : 2'b00);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) state_next = GET_MSW;
      end
      GET_MSW: begin
        in_ready = !reset;
        if (in_valid && !reset) state_next = SCAN;
      end
      SCAN: begin
        if (cnt_reg == 5'd15) state_next = FIX;
      end
      FIX: begin
        state_next = OUT_LSW;
      end
      OUT_LSW: begin
        if (out_fire) state_next = OUT_MSW;
      end
      OUT_MSW: begin
        if (out_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      w_reg          <= 16'h0000;
      s_reg          <= 4'd0;
      p_reg          <= 1'b0;
      cnt_reg        <= 5'd0;
      out_data_reg   <= 8'h00;
      out_msw_reg    <= 8'h00;
      out_valid_reg  <= 1'b0;
      corr_count_reg <= 8'h00;
      dbl_count_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_fire) w_reg[7:0] <= in_data;
        end
        GET_MSW: begin
          if (in_fire) begin
            w_reg[15:8] <= in_data;
            s_reg       <= 4'd0;
            p_reg       <= 1'b0;
            cnt_reg     <= 5'd0;
          end
        end
        SCAN: begin
          if (w_reg[cnt_reg[3:0]]) begin
            s_reg <= s_reg ^ cnt_reg[3:0];
            p_reg <= ~p_reg;
          end
          cnt_reg <= cnt_reg + 5'd1;
        end
        FIX: begin
          w_reg         <= w_fixed;
          out_data_reg  <= {w_fixed[12:9], w_fixed[7:5], w_fixed[3]};
          out_msw_reg   <= {status, 3'b000, w_fixed[15:13]};
          out_valid_reg <= 1'b1;
          if (status == 2'b01 && corr_count_reg != 8'hFF)
            corr_count_reg <= corr_count_reg + 8'd1;
          if (status == 2'b10 && dbl_count_reg != 8'hFF)
            dbl_count_reg <= dbl_count_reg + 8'd1;
        end
        OUT_LSW: begin
          if (out_fire) out_data_reg <= out_msw_reg;
        end
        OUT_MSW: begin
          if (out_fire) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder: decodes, latency, back-pressure,
// mid-scan reset and counter saturation.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [7:0] corr_count;
  logic [7:0] dbl_count;

  int n_checks = 0;
  int n_pass   = 0;

  hamming_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .corr_count (corr_count),
    .dbl_count  (dbl_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte; returns just after the accepting edge.
  task automatic send_byte(input string tag, input logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (n < 60 && !ok) begin
      if (in_ready) ok = 1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check({tag, "_accept_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic recv_byte(input string tag, output logic [7:0] b);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      check({tag, "_out_timeout"}, 16'd0, 16'd1);
      b = 8'hxx;
    end else begin
      b = out_data;
      tick();
    end
  endtask

  task automatic decode(input string tag, input logic [7:0] lsw, input logic [7:0] msw,
                        input logic [7:0] exp_lsw, input logic [7:0] exp_msw);
    logic [7:0] r0, r1;
    send_byte(tag, lsw);
    send_byte(tag, msw);
    recv_byte(tag, r0);
    recv_byte(tag, r1);
    check({tag, "_lsw"}, {8'h0, r0}, {8'h0, exp_lsw});
    check({tag, "_msw"}, {8'h0, r1}, {8'h0, exp_msw});
    $display("xfer %s in=%h_%h out=%h_%h corr=%0d dbl=%0d", tag, msw, lsw, r1, r0,
             corr_count, dbl_count);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [7:0] r0, r1;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", {15'h0, in_ready}, 16'd0);
    check("rst_out_valid", {15'h0, out_valid}, 16'd0);
    check("rst_out_data", {8'h0, out_data}, 16'h00);
    check("rst_busy", {15'h0, busy}, 16'd0);
    check("rst_counts", {corr_count, dbl_count}, 16'h0000);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {15'h0, in_ready}, 16'd1);

    decode("clean", 8'h0F, 8'h00, 8'h01, 8'h00);
    check("clean_counts", {corr_count, dbl_count}, 16'h0000);

    decode("single_b5", 8'h2F, 8'h00, 8'h01, 8'h40);
    check("single_counts", {corr_count, dbl_count}, 16'h0100);

    decode("p0_only", 8'h0E, 8'h00, 8'h01, 8'h40);
    check("p0_counts", {corr_count, dbl_count}, 16'h0200);

    decode("double", 8'h6F, 8'h00, 8'h07, 8'h80);
    check("double_counts", {corr_count, dbl_count}, 16'h0201);

    // All-ones: latency and back-pressure hold.
    out_ready = 1'b0;
    send_byte("ones", 8'hFF);
    check("getmsw_busy", {15'h0, busy}, 16'd1);
    send_byte("ones", 8'hFF);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("ones_latency", lat[15:0], 16'd17);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", {8'h0, out_data}, 16'h00FF);
      check("hold_in_ready", {out_valid, in_ready}, 16'b10);
    end
    recv_byte("ones", r0);
    recv_byte("ones", r1);
    check("ones_lsw", {8'h0, r0}, 16'h00FF);
    check("ones_msw", {8'h0, r1}, 16'h0007);
    $display("xfer ones in=ff_ff out=%h_%h latency=%0d", r1, r0, lat);

    // Reset while cnt=7 in SCAN.
    send_byte("midscan", 8'h0F);
    send_byte("midscan", 8'h00);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    #1;
    check("midscan_rst_in_ready", {15'h0, in_ready}, 16'd0);
    tick();
    reset = 1'b0;
    #1;
    check("midscan_busy", {15'h0, busy}, 16'd0);
    check("midscan_in_ready", {15'h0, in_ready}, 16'd1);
    check("midscan_out_valid", {15'h0, out_valid}, 16'd0);
    check("midscan_counts", {corr_count, dbl_count}, 16'h0000);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    check("midscan_no_output", {15'h0, seen}, 16'd0);
    $display("xfer midscan_reset discarded");

    decode("clean_after_rst", 8'h0F, 8'h00, 8'h01, 8'h00);

    // 256 single-error words: counter must stop at 0xFF.
    for (int i = 0; i < 256; i++) begin
      send_byte("sat", 8'h2F);
      send_byte("sat", 8'h00);
      recv_byte("sat", r0);
      recv_byte("sat", r1);
      if (i == 255) begin
        check("sat_last_lsw", {8'h0, r0}, 16'h0001);
        check("sat_last_msw", {8'h0, r1}, 16'h0040);
      end
    end
    check("sat_counts", {corr_count, dbl_count}, 16'hFF00);
    $display("xfer saturation corr=%0d dbl=%0d", corr_count, dbl_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
